fnd_scan_driver: RTL and testbench

Time-multiplexed 4-digit seven-segment (FND) driver downstream of the speed/score digit converters. Accepts four BCD digit codes (0–9 shown, 10–15 blank), latches them once per scan frame, and scans them onto shared segment lines with one-hot common select and anti-ghosting dead time. Sits between the game's digit producers and the board FND pins.

---
 rtl/fnd_pkg.sv | 28 ++
 rtl/fnd_seg_decoder.sv | 27 ++
 rtl/fnd_scan_driver.sv | 147 ++++++++++++++
 tb/tb_fnd_scan_driver.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared FND constants: blank code and active-high segment patterns (bit0 = a ... bit6 = g).
// Also consumed by the speed/score digit converters.
package fnd_pkg;

  localparam logic [3:0] FND_BLANK = 4'd10;
  localparam logic [6:0] SEG_OFF   = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;

  typedef logic [1:0] fnd_slot_t;

  function automatic logic [6:0] seg_polarity(input logic [6:0] pat, input logic active_low);
    if (active_low) begin
      seg_polarity = ~pat;
    end else begin
      seg_polarity = pat;
    end
  endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Combinational BCD code to active-high seven-segment pattern; codes 10-15 are blank.
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_pat
);

  // Pattern lookup; any non-decimal code leaves the digit dark.
  always_comb begin
    o_pat = SEG_OFF;
    case (i_code)
      4'd0:    o_pat = SEG_0;
      4'd1:    o_pat = SEG_1;
      4'd2:    o_pat = SEG_2;
      4'd3:    o_pat = SEG_3;
      4'd4:    o_pat = SEG_4;
      4'd5:    o_pat = SEG_5;
      4'd6:    o_pat = SEG_6;
      4'd7:    o_pat = SEG_7;
      4'd8:    o_pat = SEG_8;
      4'd9:    o_pat = SEG_9;
      default: o_pat = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// Four-digit multiplexed FND driver: frame-latched digit shadows, dead time per slot, registered pins.
// Optional per-digit blinking is compiled in when FND_BLINK_EN is defined.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEAD_CYC       = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int COM_ACTIVE_LOW = 1
`ifdef FND_BLINK_EN
  ,
  parameter int BLINK_FRAMES   = 125
`endif
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_digit0,
  input  logic [3:0] i_digit1,
  input  logic [3:0] i_digit2,
  input  logic [3:0] i_digit3,
`ifdef FND_BLINK_EN
  input  logic [3:0] i_blink_mask,
`endif
  output logic [6:0] o_seg,
  output logic [3:0] o_com,
  output logic       o_frame
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);
  localparam logic [6:0] SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [3:0] COM_IDLE = (COM_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  logic [CW-1:0]   r_cnt;
  fnd_slot_t       r_idx;
  logic [3:0][3:0] r_shadow;
  logic [6:0]      r_seg;
  logic [3:0]      r_com;
  logic            r_frame;
  logic            w_slot_end;
  logic            w_frame_end;
  logic [3:0]      w_code;
  logic [6:0]      w_pat;
  logic [3:0]      w_com_sel;
  logic [3:0]      w_com_pin;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == 2'd3);

  // Slot timing and frame-boundary capture of the digit codes, so a frame never tears.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= {CW{1'b0}};
      r_idx    <= 2'd0;
      r_shadow <= {FND_BLANK, FND_BLANK, FND_BLANK, FND_BLANK};
    end else begin
      if (w_slot_end) begin
        r_cnt <= {CW{1'b0}};
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
      if (w_frame_end) begin
        r_shadow <= {i_digit3, i_digit2, i_digit1, i_digit0};
      end
    end
  end

`ifdef FND_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] r_frm_cnt;
  logic          r_phase;
  logic [3:0]    r_mask_sh;

  // Blink phase flips every BLINK_FRAMES frames; the mask is captured with the digits.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frm_cnt <= {FW{1'b0}};
      r_phase   <= 1'b1;
      r_mask_sh <= 4'h0;
    end else if (w_frame_end) begin
      r_mask_sh <= i_blink_mask;
      if (r_frm_cnt == FRM_LAST) begin
        r_frm_cnt <= {FW{1'b0}};
        r_phase   <= ~r_phase;
      end else begin
        r_frm_cnt <= r_frm_cnt + {{(FW-1){1'b0}}, 1'b1};
      end
    end
  end
`endif

  // Code for the slot being scanned, forced blank while a masked digit is in its off phase.
  always_comb begin
    w_code = r_shadow[r_idx];
`ifdef FND_BLINK_EN
    if (!r_phase && r_mask_sh[r_idx]) begin
      w_code = FND_BLANK;
    end else begin
      w_code = r_shadow[r_idx];
    end
`endif
  end

  fnd_seg_decoder u_dec (
    .i_code (w_code),
    .o_pat  (w_pat)
  );

  // Common select for the current slot at pin polarity.
  always_comb begin
    w_com_sel = 4'b0001 << r_idx;
    if (COM_ACTIVE_LOW != 0) begin
      w_com_pin = ~w_com_sel;
    end else begin
      w_com_pin = w_com_sel;
    end
  end

  // Pin registers: the first DEAD_CYC cycles of every slot keep all commons off.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_seg   <= SEG_IDLE;
      r_com   <= COM_IDLE;
      r_frame <= 1'b0;
    end else begin
      r_frame <= (r_cnt == {CW{1'b0}}) && (r_idx == 2'd0);
      if (r_cnt < CNT_DEAD) begin
        r_seg <= SEG_IDLE;
        r_com <= COM_IDLE;
      end else begin
        r_seg <= seg_polarity(w_pat, SEG_ACTIVE_LOW != 0);
        r_com <= w_com_pin;
      end
    end
  end

  assign o_seg   = r_seg;
  assign o_com   = r_com;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Bench for fnd_scan_driver with DIV = 10, DEAD_CYC = 2, both polarities active-low.
// Per-cycle expectations for a whole frame are queued when digits are driven and popped as pins are sampled.
`timescale 1ns/1ps
module tb_fnd_scan_driver;

  localparam int DIV   = 10;
  localparam int DEAD  = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] d0, d1, d2, d3;
`ifdef FND_BLINK_EN
  logic [3:0] blink_mask;
`endif
  logic [6:0] seg;
  logic [3:0] com;
  logic       frame;

  fnd_scan_driver #(
    .CLK_HZ(1000), .SCAN_HZ(100), .DEAD_CYC(2), .SEG_ACTIVE_LOW(1), .COM_ACTIVE_LOW(1)
`ifdef FND_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_digit0(d0), .i_digit1(d1), .i_digit2(d2), .i_digit3(d3),
`ifdef FND_BLINK_EN
    .i_blink_mask(blink_mask),
`endif
    .o_seg(seg), .o_com(com), .o_frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [6:0] seg; logic [3:0] com; logic frame; } obs_t;
  typedef struct packed { logic [15:0] codes; logic [27:0] pats; } vec_t;

  obs_t sb_q[$];
  vec_t vecs[5];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue pin expectations for one frame showing active-high patterns {p3,p2,p1,p0}.
  task automatic expect_frame(input logic [27:0] pats);
    for (int k = 0; k < FRAME; k++) begin
      obs_t e;
      int s;
      int c;
      s = k / DIV;
      c = k % DIV;
      e.frame = (k == 0);
      if (c < DEAD) begin
        e.seg = 7'h7F;
        e.com = 4'hF;
      end else begin
        e.seg = ~pats[s*7 +: 7];
        e.com = ~(4'b0001 << s);
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame !== 1'b1 && n < 100);
    chk("frame_wait", {31'd0, frame}, 32'd1);
  endtask

  // Compare one frame against the queue; optionally change digit0 after cycle chg_k.
  task automatic check_frame(input bit do_wait, input int chg_k, input logic [3:0] chg_val);
    if (do_wait) wait_frame();
    for (int k = 0; k < FRAME; k++) begin
      obs_t e;
      if (k > 0) @(negedge clk);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: got empty queue want entry at k=%0d", k);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("seg k=%0d", k), {25'd0, seg}, {25'd0, e.seg});
        chk($sformatf("com k=%0d", k), {28'd0, com}, {28'd0, e.com});
        chk($sformatf("frame k=%0d", k), {31'd0, frame}, {31'd0, e.frame});
      end
      if (k == chg_k) d0 = chg_val;
    end
    @(negedge clk);
    chk("frame_period", {31'd0, frame}, 32'd1);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("reset_seg", {25'd0, seg}, 32'h7F);
      chk("reset_com", {28'd0, com}, 32'hF);
      chk("reset_frame", {31'd0, frame}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("first_frame", {31'd0, frame}, 32'd1);
  endtask

  initial begin
    logic [27:0] p;
    vecs[0] = '{codes: {4'd7, 4'd1, 4'd3, 4'd0},    pats: {7'h07, 7'h06, 7'h4F, 7'h3F}};
    vecs[1] = '{codes: {4'd4, 4'd2, 4'd9, 4'd8},    pats: {7'h66, 7'h5B, 7'h6F, 7'h7F}};
    vecs[2] = '{codes: {4'd15, 4'd10, 4'd6, 4'd5},  pats: {7'h00, 7'h00, 7'h7D, 7'h6D}};
    vecs[3] = '{codes: {4'd10, 4'd11, 4'd12, 4'd15}, pats: 28'h0};
    vecs[4] = '{codes: {4'd0, 4'd9, 4'd2, 4'd4},    pats: {7'h3F, 7'h6F, 7'h5B, 7'h66}};

    {d3, d2, d1, d0} = {4'd8, 4'd8, 4'd8, 4'd8};
`ifdef FND_BLINK_EN
    blink_mask = 4'b0000;
`endif
    do_reset(3);
    expect_frame(28'h0);
    check_frame(1'b0, -1, 4'd0);

    for (int i = 0; i < 5; i++) begin
      {d3, d2, d1, d0} = vecs[i].codes;
      expect_frame(vecs[i].pats);
      check_frame(1'b1, -1, 4'd0);
    end

    // Digit0 changes 5 -> 7 inside slot 0: current frame keeps 5, next frame shows 7.
    {d3, d2, d1, d0} = {4'd0, 4'd0, 4'd0, 4'd5};
    expect_frame({7'h3F, 7'h3F, 7'h3F, 7'h6D});
    check_frame(1'b1, -1, 4'd0);
    expect_frame({7'h3F, 7'h3F, 7'h3F, 7'h6D});
    check_frame(1'b0, 5, 4'd7);
    expect_frame({7'h3F, 7'h3F, 7'h3F, 7'h07});
    check_frame(1'b0, -1, 4'd0);

    // Reset in the middle of slot 1 blanks pins at once and clears the shadows.
    repeat (15) @(negedge clk);
    do_reset(1);
    expect_frame(28'h0);
    check_frame(1'b0, -1, 4'd0);

`ifdef FND_BLINK_EN
    {d3, d2, d1, d0} = {4'd1, 4'd2, 4'd3, 4'd4};
    blink_mask = 4'b0001;
    do_reset(2);
    for (int f = 1; f <= 6; f++) begin
      p = {7'h06, 7'h5B, 7'h4F, 7'h66};
      if (((f / 2) % 2) == 1) p[6:0] = 7'h00;
      expect_frame(p);
      check_frame(f == 1, -1, 4'd0);
    end
    repeat (5) @(negedge clk);
    do_reset(1);
    expect_frame(28'h0);
    check_frame(1'b0, -1, 4'd0);
    expect_frame({7'h06, 7'h5B, 7'h4F, 7'h66});
    check_frame(1'b0, -1, 4'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
